bt_cmd_decoder: RTL
===================

Name: bt_cmd_decoder

Overview:
Upstream stage of the servo controller. Receives the Bluetooth module's UART stream (8N1) and validates 3-byte command frames. Emits one-cycle ccw_cmd / cw_cmd pulses that drive the servo controller's inputs of the same names. Also flags malformed frames.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 9600, UART bit rate; BIT_CYC = CLK_HZ/BAUD (5208 at defaults), HALF_CYC = BIT_CYC/2 (2604)
TIMEOUT_CYC, 5_000_000, inter-byte timeout inside a frame (100 ms)
RATE_GAP_CYC, 25_000_000, minimum spacing between emitted commands (500 ms); used only with the optional feature

Ports:
clk  in  1  system clock; the block uses only this one clock
rst  in  1  synchronous, active-high reset
bt_rx  in  1  UART RX line from the Bluetooth module; asynchronous, idles high
ccw_cmd  out  1  one-cycle pulse: rotate counter-clockwise 90 degrees
cw_cmd  out  1  one-cycle pulse: rotate clockwise 90 degrees
rx_byte  out  8  last received byte; held until the next byte arrives
rx_byte_valid  out  1  one-cycle pulse when rx_byte updates
frame_err  out  1  one-cycle pulse on a UART framing error, bad checksum, bad opcode or timeout
cmd_drop  out  1  one-cycle pulse when a valid command is suppressed by rate limiting; constant 0 when the feature is absent

Behaviour:
- Reset values: all outputs 0, rx_byte = 8'h00, receiver in RX_IDLE, parser in P_HDR, all counters 0.
- bt_rx passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Receiver FSM:
  - RX_IDLE: on a synchronized high-to-low edge, go to RX_START and clear the bit counter.
  - RX_START: at HALF_CYC, sample the line. If low, go to RX_DATA. If high, treat as a false start and return to RX_IDLE.
  - RX_DATA: sample every BIT_CYC. Take 8 bits, LSB first, then go to RX_STOP.
  - RX_STOP: sample after BIT_CYC. If high, load rx_byte and pulse rx_byte_valid on the next cycle, then return to RX_IDLE. If low, pulse frame_err, discard the byte and go to RX_WAIT_IDLE.
  - RX_WAIT_IDLE: wait for the line to return high, then go to RX_IDLE.
- Frame format: 0xAA header, opcode, checksum. Checksum = 0xAA XOR opcode. Opcode 0x01 = CCW, 0x02 = CW.
- Parser FSM, advanced only on rx_byte_valid:
  - P_HDR: byte 0xAA goes to P_CMD. Any other byte is silently ignored.
  - P_CMD: store the opcode (any value, including 0xAA) and go to P_SUM.
  - P_SUM: if the checksum matches and the opcode is 0x01 or 0x02, pulse the matching output on the cycle after rx_byte_valid. Otherwise pulse frame_err. Always return to P_HDR.
- Timeout: in P_CMD or P_SUM, a counter clears on each rx_byte_valid. If it reaches TIMEOUT_CYC, pulse frame_err and return to P_HDR. The timeout is inactive in P_HDR.
- A receiver framing error while the parser is in P_CMD or P_SUM also returns the parser to P_HDR. Only one frame_err pulse is issued for that event.
- Output exclusivity: ccw_cmd and cw_cmd are never high together. At most one command pulse occurs per frame.
- Latency: the command pulse rises 2 cycles after the stop-bit sample of the checksum byte.
- Reset mid-byte or mid-frame: all state is abandoned and no pulse is emitted. After reset deasserts, a partial byte still on the line is resynchronized via the RX_IDLE edge rule.
- Counters are sized to hold max(TIMEOUT_CYC, RATE_GAP_CYC) and saturate at their terminal value.

Optional Feature:
BT_CMD_RATE_LIMIT_EN
- Defined:
  - After a command pulse, a gap counter runs for RATE_GAP_CYC cycles.
  - A valid frame completing while the gap counter is running produces cmd_drop instead of a command pulse.
  - A dropped frame does not restart the gap counter.
  - frame_err handling is unchanged.
- Not defined: the gap counter and its logic are absent, cmd_drop is tied to 0, and every valid frame produces a command pulse.

Decomposition:
- Shared package bt_cmd_pkg holds:
  - HDR_BYTE = 8'hAA, OP_CCW = 8'h01, OP_CW = 8'h02
  - the receiver state encoding (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE)
  - the parser state encoding (P_HDR, P_CMD, P_SUM)
- One sub-module, uart_rx_core, contains the synchronizer, the receiver FSM and the bit counter. It outputs the byte, the valid pulse and the framing-error pulse.
- The parser, timeout and rate limiter stay in bt_cmd_decoder.

Test Plan:
1. Send bytes AA 01 AB at 9600 baud -> exactly one ccw_cmd pulse, 1 cycle wide, 2 cycles after the last stop-bit sample; no frame_err.
2. Send 55 AA 02 A8 -> the 0x55 is ignored; one cw_cmd pulse; three rx_byte_valid pulses for the frame bytes plus one for 0x55.
3. Send AA 01 00 -> frame_err pulse; no command. Then send AA 03 A9 -> frame_err (bad opcode); no command.
4. Send AA, then idle 5_000_000 cycles -> frame_err at the timeout. A following 01 AB is ignored, because 0x01 is not a header.
5. Drive a 1000-cycle low glitch on an idle line -> false start, no rx_byte_valid. Then drive a byte with its stop bit held low -> frame_err, and reception recovers after the line returns high.
6. With BT_CMD_RATE_LIMIT_EN defined: send AA 02 A8 twice, 1 ms apart -> one cw_cmd pulse, then one cmd_drop pulse. A third frame at 600 ms -> cw_cmd. Also assert rst mid-frame -> no pulses, and the parser is in P_HDR.

Source files
------------

// File: rtl/bt_cmd_pkg.sv
// Shared definitions for the Bluetooth command decoder.
// Holds the frame byte constants, the receiver and parser state encodings,
// and two small helper functions used by the decoder.
package bt_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam logic [7:0] OP_CCW   = 8'h01;
  localparam logic [7:0] OP_CW    = 8'h02;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef enum logic [1:0] {
    P_HDR,
    P_CMD,
    P_SUM
  } p_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic op_is_valid(input logic [7:0] op);
    return (op == OP_CCW) || (op == OP_CW);
  endfunction

endpackage

// File: rtl/bt_cmd_decoder_uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver for the Bluetooth RX line.
// Synchronizes the asynchronous line, finds start bits on a falling edge,
// samples each bit near its centre and checks the stop bit.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   rx_i    in   raw UART line (asynchronous, idles high)
//   byte_o  out  last good byte, held until the next one
//   valid_o out  one-cycle pulse when byte_o updates
//   ferr_o  out  one-cycle pulse when the stop bit is sampled low
module uart_rx_core
  import bt_cmd_pkg::*;
#(
  parameter int unsigned BIT_CYC  = 5208,
  parameter int unsigned HALF_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int unsigned CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer flops reset to the idle level so reset itself never
      // looks like a start edge on a quiet line.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      RX_START: begin
        // Half a bit after the edge we are mid start bit; a high line here
        // means the edge was a glitch.
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};  // LSB arrives first
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (sync2_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        // A broken byte may leave the line low; only re-arm once it idles.
        if (sync2_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: turns the Bluetooth UART stream into servo commands.
// Frames are AA <opcode> <AA^opcode>; opcode 01 pulses ccw_cmd, 02 pulses
// cw_cmd. Bad checksums, bad opcodes, UART framing errors and inter-byte
// timeouts inside a frame pulse frame_err.
//
// Optional build macro BT_CMD_RATE_LIMIT_EN: when defined, commands closer
// than RATE_GAP_CYC to the previous emitted command are replaced by a
// cmd_drop pulse. Without it, cmd_drop is constant 0.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   bt_rx         in   UART RX line (asynchronous, idles high)
//   ccw_cmd       out  one-cycle counter-clockwise command pulse
//   cw_cmd        out  one-cycle clockwise command pulse
//   rx_byte       out  last received byte
//   rx_byte_valid out  one-cycle pulse when rx_byte updates
//   frame_err     out  one-cycle pulse on any malformed frame or timeout
//   cmd_drop      out  one-cycle pulse when a valid command is rate limited
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned TIMEOUT_CYC  = 5_000_000,
  parameter int unsigned RATE_GAP_CYC = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_rx,
  output logic       ccw_cmd,
  output logic       cw_cmd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       cmd_drop
);

  localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_MAX  = max_u(TIMEOUT_CYC, RATE_GAP_CYC);
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_core #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_i    (bt_rx),
    .byte_o  (rx_data),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  p_state_e         pstate_q, pstate_d;
  logic [7:0]       op_q, op_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             ccw_q, ccw_d;
  logic             cw_q, cw_d;
  logic             ferr_q, ferr_d;
  logic             sum_ok;
`ifdef BT_CMD_RATE_LIMIT_EN
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(RATE_GAP_CYC);
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             drop_q, drop_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate_q <= P_HDR;
      op_q     <= '0;
      tmo_q    <= '0;
      ccw_q    <= 1'b0;
      cw_q     <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef BT_CMD_RATE_LIMIT_EN
      gap_q    <= '0;
      drop_q   <= 1'b0;
`endif
    end else begin
      pstate_q <= pstate_d;
      op_q     <= op_d;
      tmo_q    <= tmo_d;
      ccw_q    <= ccw_d;
      cw_q     <= cw_d;
      ferr_q   <= ferr_d;
`ifdef BT_CMD_RATE_LIMIT_EN
      gap_q    <= gap_d;
      drop_q   <= drop_d;
`endif
    end
  end

  // Checksum byte is current rx_data while in P_SUM.
  assign sum_ok = (rx_data == (HDR_BYTE ^ op_q)) && op_is_valid(op_q);

  always_comb begin
    pstate_d = pstate_q;
    op_d     = op_q;
    tmo_d    = tmo_q;
    ccw_d    = 1'b0;
    cw_d     = 1'b0;
    // UART framing errors always surface; parser errors are OR-ed in so a
    // framing error inside a frame still yields a single pulse.
    ferr_d   = rx_ferr;
`ifdef BT_CMD_RATE_LIMIT_EN
    drop_d   = 1'b0;
    gap_d    = (gap_q != '0) ? gap_q - CNT_W'(1) : '0;
`endif
    case (pstate_q)
      P_HDR: begin
        tmo_d = '0;
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          pstate_d = P_CMD;
        end
      end
      P_CMD, P_SUM: begin
        if (rx_ferr) begin
          pstate_d = P_HDR;
          tmo_d    = '0;
        end else if (rx_valid) begin
          tmo_d = '0;
          if (pstate_q == P_CMD) begin
            op_d     = rx_data;
            pstate_d = P_SUM;
          end else begin
            pstate_d = P_HDR;
            if (sum_ok) begin
`ifdef BT_CMD_RATE_LIMIT_EN
              if (gap_q != '0) begin
                drop_d = 1'b1;  // dropped frames leave the gap running as is
              end else begin
                ccw_d = (op_q == OP_CCW);
                cw_d  = (op_q == OP_CW);
                gap_d = GAP_LOAD;
              end
`else
              ccw_d = (op_q == OP_CCW);
              cw_d  = (op_q == OP_CW);
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end
        end else if (tmo_q >= TMO_LAST) begin
          ferr_d   = 1'b1;
          pstate_d = P_HDR;
          tmo_d    = '0;
        end else if (tmo_q != CNT_TOP) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      default: pstate_d = P_HDR;
    endcase
  end

  assign ccw_cmd       = ccw_q;
  assign cw_cmd        = cw_q;
  assign rx_byte       = rx_data;
  assign rx_byte_valid = rx_valid;
  assign frame_err     = ferr_q;
`ifdef BT_CMD_RATE_LIMIT_EN
  assign cmd_drop      = drop_q;
`else
  assign cmd_drop      = 1'b0;
`endif

endmodule
